ex_mem_wb_pipe: RTL and testbench

//  EX/MEM and MEM/WB pipeline registers for the 5-stage RISC-V core. Supplies rd/reg_write per stage
//  to the forwarding unit and result data to the EX operand muxes.

---
 rtl/ex_mem_wb_pipe.sv | 181 ++++++++++++++++++
 tb/tb_ex_mem_wb_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB pipeline registers of the 5-stage RISC-V core,
// plus the data-memory wait FSM (with timeout), memory stall and load-use detection.
// Optional feature macro: PIPE_STALL_CNT_EN adds a saturating stall_cycles counter port.
`timescale 1ns/1ps

module ex_mem_wb_pipe #(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [4:0]        ex_rs1,
    input  logic [4:0]        ex_rs2,
    input  logic              flush_ex,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [4:0]        rd_EX_MEM,
    output logic              reg_write_EX_MEM,
    output logic              mem_read_EX_MEM,
    output logic [DATA_W-1:0] alu_result_EX_MEM,
    output logic [4:0]        rd_MEM_WB,
    output logic              reg_write_MEM_WB,
    output logic [DATA_W-1:0] wb_data_MEM_WB,
    output logic              stall,
    output logic              load_use_hazard,
    output logic              mem_timeout
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int            CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(MEM_TIMEOUT);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              w_force_done;

    logic [4:0]        r_rd_em;
    logic              r_rw_em;
    logic              r_mr_em;
    logic [DATA_W-1:0] r_alu_em;
    logic [4:0]        r_rd_mw;
    logic              r_rw_mw;
    logic [DATA_W-1:0] r_wb_mw;
    logic              r_timeout;

    logic              w_load;
    logic              w_stall;
    logic              w_hazard;
    logic              w_bubble;
    logic [DATA_W-1:0] w_wb_data;

    // A load only matters for waiting when it will actually write a register
    assign w_load    = r_mr_em & r_rw_em;
    assign w_stall   = w_load & ~mem_ready & ~w_force_done;
    assign w_hazard  = r_rw_em & r_mr_em & ((r_rd_em == ex_rs1) | (r_rd_em == ex_rs2)) & ex_valid;
    assign w_bubble  = flush_ex | ~ex_valid | w_hazard;
    // A force-completed load writes zero rather than whatever is on the bus
    assign w_wb_data = r_mr_em ? (w_force_done ? '0 : mem_rdata) : r_alu_em;

    assign rd_EX_MEM         = r_rd_em;
    assign reg_write_EX_MEM  = r_rw_em;
    assign mem_read_EX_MEM   = r_mr_em;
    assign alu_result_EX_MEM = r_alu_em;
    assign rd_MEM_WB         = r_rd_mw;
    assign reg_write_MEM_WB  = r_rw_mw;
    assign wb_data_MEM_WB    = r_wb_mw;
    assign stall             = w_stall;
    assign load_use_hazard   = w_hazard;
    assign mem_timeout       = r_timeout;

    // Memory wait FSM state and wait counter
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: enter WAIT on a load without data, leave on data or on timeout
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_force_done = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_load && !mem_ready) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TO) begin
                    w_force_done = 1'b1;
                    w_state_nxt  = S_RUN;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // EX/MEM register: hold on stall (flush cannot kill the older load), else bubble or capture
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rd_em  <= '0;
            r_rw_em  <= 1'b0;
            r_mr_em  <= 1'b0;
            r_alu_em <= '0;
        end else if (!w_stall) begin
            if (w_bubble) begin
                r_rd_em  <= '0;
                r_rw_em  <= 1'b0;
                r_mr_em  <= 1'b0;
                r_alu_em <= '0;
            end else begin
                r_rd_em  <= ex_rd;
                r_rw_em  <= ex_reg_write & (ex_rd != 5'd0);
                r_mr_em  <= ex_mem_read;
                r_alu_em <= ex_alu_result;
            end
        end
    end

    // MEM/WB register: bubble while the load waits, otherwise retire EX/MEM
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rd_mw <= '0;
            r_rw_mw <= 1'b0;
            r_wb_mw <= '0;
        end else if (w_stall) begin
            r_rd_mw <= '0;
            r_rw_mw <= 1'b0;
            r_wb_mw <= '0;
        end else begin
            r_rd_mw <= r_rd_em;
            r_rw_mw <= r_rw_em;
            r_wb_mw <= w_wb_data;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or posedge arst) begin
        if (arst)              r_timeout <= 1'b0;
        else if (w_force_done) r_timeout <= 1'b1;
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cycles;
    assign stall_cycles = r_stall_cycles;

    // Saturating count of cycles lost to memory stalls or load-use hazards
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_stall_cycles <= '0;
        else if ((w_stall || w_hazard) && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Scoreboard bench for ex_mem_wb_pipe: retiring instructions are queued as {rd,data}
// when issued and matched against MEM/WB write-backs; pipeline controls checked directly.
`timescale 1ns/1ps

module tb_ex_mem_wb_pipe;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          ex_valid, ex_reg_write, ex_mem_read, flush_ex, mem_ready;
    logic [4:0]    ex_rd, ex_rs1, ex_rs2;
    logic [DW-1:0] ex_alu_result, mem_rdata;
    logic [4:0]    rd_EX_MEM, rd_MEM_WB;
    logic          reg_write_EX_MEM, mem_read_EX_MEM, reg_write_MEM_WB;
    logic [DW-1:0] alu_result_EX_MEM, wb_data_MEM_WB;
    logic          stall, load_use_hazard, mem_timeout;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    ex_mem_wb_pipe #(.DATA_W(DW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .arst(arst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_alu_result(ex_alu_result),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .flush_ex(flush_ex),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rd_EX_MEM(rd_EX_MEM), .reg_write_EX_MEM(reg_write_EX_MEM),
        .mem_read_EX_MEM(mem_read_EX_MEM), .alu_result_EX_MEM(alu_result_EX_MEM),
        .rd_MEM_WB(rd_MEM_WB), .reg_write_MEM_WB(reg_write_MEM_WB),
        .wb_data_MEM_WB(wb_data_MEM_WB),
        .stall(stall), .load_use_hazard(load_use_hazard), .mem_timeout(mem_timeout)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [36:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [31:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic fl);
        ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
        ex_alu_result = alu; ex_rs1 = rs1; ex_rs2 = rs2; flush_ex = fl;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Every write-back must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!arst && reg_write_MEM_WB) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected_rd", 32'(rd_MEM_WB), 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                chk("wb_rd", 32'(rd_MEM_WB), 32'(e[36:32]));
                chk("wb_data", wb_data_MEM_WB, e[31:0]);
            end
        end
    end

    initial begin
        int n;
        arst = 1'b1; idle(); mem_ready = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_rdE", 32'(rd_EX_MEM), 0);
        chk("rst_rwE", 32'(reg_write_EX_MEM), 0);
        chk("rst_rwW", 32'(reg_write_MEM_WB), 0);
        chk("rst_wb",  wb_data_MEM_WB, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_to", 32'(mem_timeout), 0);
        @(posedge clk); #1 arst = 1'b0;

        // 1: plain ALU op
        mem_ready = 1'b1;
        drv(1'b1, 5'd5, 1'b1, 1'b0, 32'h11, 5'd1, 5'd2, 1'b0);
        sb_q.push_back({5'd5, 32'h11});
        step(); idle();
        chk("alu_rdE", 32'(rd_EX_MEM), 5);
        chk("alu_rwE", 32'(reg_write_EX_MEM), 1);
        chk("alu_resE", alu_result_EX_MEM, 32'h11);
        step();

        // 2: writes to x0 never retire
        drv(1'b1, 5'd0, 1'b1, 1'b0, 32'h22, 5'd1, 5'd2, 1'b0);
        step(); idle();
        chk("x0_rwE", 32'(reg_write_EX_MEM), 0);
        step();
        chk("x0_rwW", 32'(reg_write_MEM_WB), 0);

        // 3: load-use hazard with data ready on entry (no stall)
        drv(1'b1, 5'd7, 1'b1, 1'b1, 32'h100, 5'd1, 5'd2, 1'b0);
        sb_q.push_back({5'd7, 32'hBEEF});
        step();
        drv(1'b1, 5'd9, 1'b1, 1'b0, 32'h33, 5'd3, 5'd7, 1'b0);
        mem_rdata = 32'hBEEF; #1;
        chk("lu_hazard", 32'(load_use_hazard), 1);
        chk("lu_stall", 32'(stall), 0);
        step(); idle();
        chk("lu_bubble_rwE", 32'(reg_write_EX_MEM), 0);
        chk("lu_bubble_rdE", 32'(rd_EX_MEM), 0);
        chk("lu_hazard_clr", 32'(load_use_hazard), 0);
        step();

        // 4: load waits 3 cycles, flush during the stall is ignored
        drv(1'b1, 5'd3, 1'b1, 1'b1, 32'h200, 5'd1, 5'd2, 1'b0);
        sb_q.push_back({5'd3, 32'hCAFE});
        step();
        drv(1'b1, 5'd4, 1'b1, 1'b0, 32'h44, 5'd1, 5'd1, 1'b0);
        sb_q.push_back({5'd4, 32'h44});
        mem_ready = 1'b0; mem_rdata = 32'h0BAD;
        for (int i = 0; i < 3; i++) begin
            flush_ex = (i == 1); #1;
            chk("wait_stall", 32'(stall), 1);
            step();
            chk("wait_hold_rdE", 32'(rd_EX_MEM), 3);
            chk("wait_rwW", 32'(reg_write_MEM_WB), 0);
        end
        flush_ex = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFE; #1;
        chk("wait_done_stall", 32'(stall), 0);
        step(); idle();
        chk("wait_next_rdE", 32'(rd_EX_MEM), 4);
        step();

        // 6a: flush without stall kills the instruction
        drv(1'b1, 5'd6, 1'b1, 1'b0, 32'h66, 5'd1, 5'd2, 1'b1);
        step(); idle();
        chk("flush_rwE", 32'(reg_write_EX_MEM), 0);
        step();
        chk("pre_to_flag", 32'(mem_timeout), 0);

        // 5: timeout force-completes the load with zero data
        drv(1'b1, 5'd8, 1'b1, 1'b1, 32'h300, 5'd1, 5'd2, 1'b0);
        sb_q.push_back({5'd8, 32'h0});
        step(); idle();
        mem_ready = 1'b0; mem_rdata = 32'hDEAD; #1;
        n = 0;
        while (stall && n < 20) begin n++; step(); end
        chk("to_stall_cycles", 32'(n), TO);
        step();
        chk("to_flag", 32'(mem_timeout), 1);
        chk("to_nonload_ignores_ready", 32'(stall), 0);
        repeat (3) step();
        chk("to_flag_sticky", 32'(mem_timeout), 1);

        // 6b: reset in WAIT abandons the load
        drv(1'b1, 5'd10, 1'b1, 1'b1, 32'h400, 5'd1, 5'd2, 1'b0);
        step(); idle();
        step();
        chk("pre_rst_stall", 32'(stall), 1);
        arst = 1'b1; #1;
        chk("arst_rdE", 32'(rd_EX_MEM), 0);
        chk("arst_rwE", 32'(reg_write_EX_MEM), 0);
        chk("arst_stall", 32'(stall), 0);
        chk("arst_rwW", 32'(reg_write_MEM_WB), 0);
        chk("arst_to", 32'(mem_timeout), 0);
        step(); arst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h77;
        drv(1'b1, 5'd11, 1'b1, 1'b1, 32'h500, 5'd1, 5'd2, 1'b0);
        sb_q.push_back({5'd11, 32'h77});
        step(); idle(); #1;
        chk("post_rst_no_stall", 32'(stall), 0);
        repeat (4) step();

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
